// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the line-granular external memory model.
// Defaults here track the L1 cache geometry so both sides agree on line size.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } mem_state_e;

  localparam int MEM_LINE_BYTES  = 32;
  localparam int MEM_DEPTH_LINES = 1024;
  localparam int MEM_LATENCY     = 10;

  localparam int MEM_OFF_W = $clog2(MEM_LINE_BYTES);
  localparam int MEM_IDX_W = $clog2(MEM_DEPTH_LINES);

endpackage

// File: rtl/mem_line_array.sv
// Single-port line storage: one full line per access, registered read, no reset
// on the array or read register so it maps onto block RAM.
module mem_line_array #(
  parameter int DEPTH = 1024,
  parameter int W     = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Main-memory responder behind L1: accepts one line read/write, acks after a fixed
// latency, then spends one GAP cycle ignoring mem_cs before accepting again.
module ext_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = MEM_LINE_BYTES,
  parameter int LINE_W      = LINE_BYTES * 8,
  parameter int DEPTH_LINES = MEM_DEPTH_LINES,
  parameter int LATENCY     = MEM_LATENCY,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_cs,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              rd_vld_q, rd_vld_d;

  logic              ram_en, ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [LINE_W-1:0] ram_rdata;
  logic [IDX_W-1:0]  req_idx;
  logic              unused_addr_bits;

  assign req_idx          = mem_addr[OFF_W+IDX_W-1:OFF_W];
  assign unused_addr_bits = ^{mem_addr[ADDR_W-1:OFF_W+IDX_W], mem_addr[OFF_W-1:0]};

  // Reads are launched on the edge entering ACK so the registered data lands in ACK.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    rd_vld_d   = rd_vld_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = idx_q;
    case (state_q)
      IDLE: begin
        if (mem_cs) begin
          we_d      = mem_we;
          idx_d     = req_idx;
          wdata_d   = mem_wdata;
          lat_cnt_d = LAT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d  = ACK;
            ram_en   = !mem_we;
            ram_addr = req_idx;
            if (!mem_we) rd_vld_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = ACK;
          ram_en  = !we_q;
          if (!we_q) rd_vld_d = 1'b1;
        end
      end
      ACK: begin
        ram_en = we_q;
        ram_we = we_q;
        if (we_q) begin
          if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
        end else begin
          if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
        end
        state_d = GAP;
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  mem_line_array #(
    .DEPTH (DEPTH_LINES),
    .W     (LINE_W),
    .AW    (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The array read register has no reset; the valid flag provides the zero reset value.
  assign mem_rdata = rd_vld_q ? ram_rdata : '0;
  assign mem_ack   = (state_q == ACK);
  assign busy      = (state_q == BUSY) || (state_q == ACK);
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=10/CNT_W=16 and LATENCY=1/CNT_W=4)
// driven by a controller-like driver, checked against a line-indexed memory model.
module tb_ext_mem_responder;

  localparam int LB = 32;
  localparam int DL = 1024;
  localparam int LW = LB * 8;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    int    due;
    bit    rd;
    line_t data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cs    [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  line_t       wdata [2];
  line_t       rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic [15:0] rdc0, wrc0;
  logic [3:0]  rdc1, wrc1;

  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;
  exp_t  sb [2][$];
  line_t mdl [int];
  line_t exp_rdata [2];
  int    exp_rd [2];
  int    exp_wr [2];
  int    acc_t  [2];

  ext_mem_responder #(.LATENCY(10), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]), .busy(busy[0]),
    .rd_count(rdc0), .wr_count(wrc0)
  );

  ext_mem_responder #(.LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]), .busy(busy[1]),
    .rd_count(rdc1), .wr_count(wrc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int u);
    return (u == 0) ? 10 : 1;
  endfunction

  function automatic int cmax_of(input int u);
    return (u == 0) ? 65535 : 15;
  endfunction

  function automatic int key_of(input int u, input logic [31:0] a);
    return u * DL + (int'(a / LB) % DL);
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_int(input string nm, input int u, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, u, cyc, got, want);
    end
  endtask

  // Monitor: compares every cycle, popping an expectation when an ack is due.
  always @(negedge clk) begin
    int   got_rd, got_wr, lat;
    bit   a_exp, b_exp;
    exp_t e;
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        lat    = lat_of(u);
        got_rd = (u == 0) ? int'(rdc0) : int'(rdc1);
        got_wr = (u == 0) ? int'(wrc0) : int'(wrc1);
        check_int("rd_count", u, got_rd, exp_rd[u]);
        check_int("wr_count", u, got_wr, exp_wr[u]);
        b_exp = (cyc > acc_t[u]) && (cyc <= acc_t[u] + lat);
        check_int("busy", u, longint'(busy[u]), longint'(b_exp));
        a_exp = (sb[u].size() != 0) && (sb[u][0].due == cyc);
        check_int("ack", u, longint'(ack[u]), longint'(a_exp));
        if (a_exp) begin
          e = sb[u].pop_front();
          if (e.rd) begin
            exp_rdata[u] = e.data;
            if (exp_rd[u] < cmax_of(u)) exp_rd[u]++;
          end else begin
            if (exp_wr[u] < cmax_of(u)) exp_wr[u]++;
          end
        end
        total++;
        if (rdata[u] !== exp_rdata[u]) begin
          bad++;
          $display("FAIL rdata dut%0d cyc=%0d got=%h want=%h", u, cyc, rdata[u], exp_rdata[u]);
        end
      end
    end
  end

  // Called at a negedge; holds cs high through reset, releases with cs low.
  task automatic do_reset(input int n);
    for (int u = 0; u < 2; u++) begin
      sb[u].delete();
      exp_rd[u]    = 0;
      exp_wr[u]    = 0;
      exp_rdata[u] = '0;
      acc_t[u]     = -1000;
      cs[u]        = 1'b1;
    end
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst   = 1'b1;
    cs[0] = 1'b0;
    cs[1] = 1'b0;
  endtask

  // Called at a negedge of an idle cycle; returns at the negedge of the next idle cycle.
  // Inputs are scrambled while the request is outstanding and cs stays high through GAP.
  task automatic do_req(input int u, input bit w, input logic [31:0] a, input line_t d,
                        input int abort_at);
    int   t, lat, k_key;
    exp_t e;
    lat   = lat_of(u);
    t     = cyc;
    k_key = key_of(u, a);
    cs[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    acc_t[u] = t;
    if (abort_at == 0) begin
      e.due  = t + lat;
      e.rd   = !w;
      e.data = (!w && mdl.exists(k_key)) ? mdl[k_key] : '0;
      sb[u].push_back(e);
      if (w) mdl[k_key] = d;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (abort_at != 0 && k == abort_at) begin
        do_reset(2);
        return;
      end
      cs[u]    = (k == lat + 1) ? 1'b1 : 1'($urandom_range(0, 1));
      we[u]    = 1'($urandom_range(0, 1));
      addr[u]  = $urandom;
      wdata[u] = rand_line();
    end
    @(negedge clk);
    cs[u] = 1'b0;
  endtask

  task automatic random_phase(input int u, input int n);
    logic [31:0] a;
    bit          w;
    for (int i = 0; i < n; i++) begin
      a        = $urandom;
      a[14:5]  = 10'($urandom_range(0, 7));
      w        = !mdl.exists(key_of(u, a)) || ($urandom_range(0, 1) == 1);
      do_req(u, w, a, rand_line(), 0);
    end
  endtask

  initial begin
    line_t pat_a5, d_old, d_new;
    logic [7:0] b;
    b      = 8'hA5;
    pat_a5 = {LB{b}};
    for (int u = 0; u < 2; u++) begin
      cs[u] = 1'b1; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
      exp_rd[u] = 0; exp_wr[u] = 0; exp_rdata[u] = '0; acc_t[u] = -1000;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cs[0] = 1'b0;
    cs[1] = 1'b0;
    repeat (2) @(negedge clk);

    do_req(0, 1'b1, 32'h0000_0040, pat_a5, 0);
    do_req(0, 1'b0, 32'h0000_0040, '0, 0);

    do_req(0, 1'b1, 32'h0000_0200, rand_line(), 0);
    do_req(0, 1'b1, 32'h0000_0100, rand_line(), 0);
    do_req(0, 1'b0, 32'h0000_0200, '0, 0);
    do_req(0, 1'b0, 32'h0000_0100, '0, 0);

    do_req(0, 1'b1, 32'h0000_805C, rand_line(), 0);
    do_req(0, 1'b0, 32'h0000_0040, '0, 0);

    d_old = rand_line();
    d_new = rand_line();
    do_req(0, 1'b1, 32'h0000_0080, d_old, 0);
    do_req(0, 1'b1, 32'h0000_0080, d_new, 4);
    repeat (2) @(negedge clk);
    do_req(0, 1'b0, 32'h0000_0080, '0, 0);

    random_phase(0, 24);

    do_req(1, 1'b1, 32'h0000_0040, rand_line(), 0);
    do_req(1, 1'b0, 32'h0000_0040, '0, 0);
    for (int i = 0; i < 18; i++) do_req(1, 1'b1, 32'h0000_0060, rand_line(), 0);
    random_phase(1, 20);

    repeat (4) @(negedge clk);
    for (int u = 0; u < 2; u++) check_int("sb_drained", u, sb[u].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Line-granular external (main) memory responder. It is the target side of the cache-to-memory handshake driven by the L1 cache controller.
- Accepts read-line and write-line requests on mem_cs/mem_we, models a fixed access latency, then returns a one-cycle mem_ack.
- Used in system simulation and in FPGA builds as the backing store behind L1.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_BYTES, 32, bytes per cache line; power of two, >= 4.
- LINE_W, LINE_BYTES*8, data bus width (one full line per transfer).
- DEPTH_LINES, 1024, number of lines stored; power of two.
- LATENCY, 10, cycles from request acceptance to mem_ack; must be >= 1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, clock; all logic on posedge.
- rst, input, 1, reset; asynchronous, active-low.
- mem_cs, input, 1, request valid from the cache controller.
- mem_we, input, 1, 1 = write line, 0 = read line; sampled with mem_cs.
- mem_addr, input, ADDR_W, byte address; offset bits are ignored.
- mem_wdata, input, LINE_W, write line data; sampled at acceptance.
- mem_rdata, output, LINE_W, read line data.
- mem_ack, output, 1, completion pulse.
- busy, output, 1, high while a request is outstanding (states BUSY, ACK).
- rd_count, output, CNT_W, number of completed reads; saturating.
- wr_count, output, CNT_W, number of completed writes; saturating.

Behaviour:
- Reset values: state = IDLE, mem_ack = 0, mem_rdata = 0, busy = 0, rd_count = 0, wr_count = 0, latency counter = 0, captured request registers = 0. Array contents are NOT reset.
- Line index = mem_addr[log2(LINE_BYTES)+log2(DEPTH_LINES)-1 : log2(LINE_BYTES)]. Upper address bits alias (modulo DEPTH_LINES).
- States:
  - IDLE: if mem_cs=1, capture mem_we, index and mem_wdata; load counter with LATENCY-1; go to BUSY, or directly to ACK when LATENCY=1. Otherwise stay in IDLE.
  - BUSY: decrement counter each cycle. Inputs are ignored, including changes to mem_cs, mem_we, mem_addr and mem_wdata. Go to ACK when counter == 1; for LATENCY=2, BUSY lasts exactly one cycle.
  - ACK:
    - mem_ack = 1 for exactly this cycle.
    - On a write, the array line is updated at the end of this cycle.
    - On a read, mem_rdata = array[index], registered so it is valid in this cycle. It holds until the next read completes; writes do not change it.
    - Increment rd_count or wr_count, saturating at all-ones.
    - Go to GAP.
  - GAP: one cycle in which mem_cs is ignored, then go to IDLE. This is mandatory: the cache controller holds mem_cs high for one cycle after ack before dropping it or issuing the next request.
- Latency: a request accepted in IDLE at cycle T raises mem_ack in cycle T+LATENCY. The earliest next acceptance is cycle T+LATENCY+2.
- Back-to-back traffic: a write-back followed by an allocate with mem_cs held high continuously is served as two independent requests, separated by GAP.
- Read after write to the same line returns the newly written data.
- mem_cs dropping during BUSY does not cancel the request; ack is still produced.
- Reset asserted mid-operation aborts the request immediately: a pending write is discarded, no ack is issued, and outputs take their reset values.
- Simultaneous read and write do not occur; only one request is outstanding at a time.

Decomposition:
- Shared package (mem_pkg):
  - state encoding IDLE=2'd0, BUSY=2'd1, ACK=2'd2, GAP=2'd3;
  - default LINE_BYTES, DEPTH_LINES and LATENCY constants, shared with the cache parameters;
  - index-extraction width constants.
- One sub-module, mem_line_array: synchronous single-port DEPTH_LINES x LINE_W storage with registered read and write enable. It must infer block RAM.
- The FSM, counter and statistics logic live in ext_mem_responder.

Test Plan:
- Reset: rst=0 for 3 cycles, then release -> mem_ack=0, busy=0, mem_rdata=0, rd_count=wr_count=0. mem_cs=1 held during reset produces no ack.
- Write then read, LATENCY=10: write 0xA5 repeated into line at addr 0x0000_0040 with mem_cs=1 at T=5 -> mem_ack only at T=15, wr_count=1. Read at 0x0000_0040 accepted at T=17 -> mem_ack at T=27, mem_rdata=0xA5 pattern, rd_count=1.
- Controller sequence, mem_cs held high:
  - write-back to 0x100 accepted at T, mem_we drops to 0 at T+LATENCY+1 for an allocate from 0x200;
  - expect acks at T+10 and T+22;
  - the read returns the 0x200 contents, the write lands at 0x100;
  - cs held through the GAP cycle does not start a spurious request.
- Aliasing and offset: write to 0x0000_805C (offset 0x1C), then read 0x0000_0040 with DEPTH_LINES=1024 -> same line (index 2), data matches.
- Reset mid-write: write to 0x80 accepted, rst pulsed at cycle 4 of BUSY -> no ack, wr_count=0, and a later read of 0x80 returns the old data.
- LATENCY=1 build: request at T -> ack at T+1, next acceptance at T+3. Force wr_count to 0xFFFF, then one more write -> wr_count remains 0xFFFF.
